// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encodings and default operand width live here.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_N = 8;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fa_dataflow.sv
// One-bit full adder in dataflow form.
// Shared building block for serial arithmetic.
module fa_dataflow (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder step per clock, LSB first.
// Result is held until the next accepted request.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         busy,
    output logic         done
);

    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e        state_q;
    logic [N-1:0]  a_q;
    logic [N-1:0]  b_q;
    logic [N-1:0]  s_q;
    logic [N-1:0]  a_d;
    logic [N-1:0]  b_d;
    logic [N-1:0]  s_d;
    logic [N:0]    s_ext;
    logic          c_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          fa_s;
    logic          fa_co;

    fa_dataflow u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .ci_i (c_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // Sum bits enter at the MSB so the LSB lands at bit 0 after N steps.
    always_comb begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        s_ext = {fa_s, s_q};
        s_d   = s_ext[N:1];
        cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= ci;
                        s_q     <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_d;
                    b_q   <= b_d;
                    s_q   <= s_d;
                    c_q   <= fa_co;
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The carry flop holds the running carry in RUN; hide it until final.
    assign s    = s_q;
    assign co   = c_q & (state_q != RUN);
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning operand width in bits, legal range 1..32.
REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-005 The module SHALL have port a, input, N bits: operand A; captured on the accepting edge.
REQ-006 The module SHALL have port b, input, N bits: operand B; captured on the accepting edge.
REQ-007 The module SHALL have port ci, input, 1 bit: carry-in; captured on the accepting edge.
REQ-008 The module SHALL have port s, output, N bits: sum result.
REQ-009 The module SHALL have port co, output, 1 bit: carry-out result.
REQ-010 The module SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-011 The module SHALL have port done, output, 1 bit: one-cycle pulse marking s and co valid.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, RUN and DONE, and SHALL reset to IDLE.
REQ-013 In IDLE with start=1, the next edge SHALL load the A and B shift registers from a and b, load the carry flop from ci, clear the bit counter, and move to RUN.
REQ-014 Operands captured on the accepting edge SHALL not be affected by later changes on a, b or ci.
REQ-015 Each RUN edge SHALL add A[0], B[0] and the carry in one full adder, then:
- store the full-adder carry in the carry flop;
- shift the sum bit into the MSB of the sum register, moving that register right by one;
- shift A and B right by one;
- increment the counter.
REQ-016 RUN SHALL last exactly N edges; the Nth RUN edge SHALL move to DONE.
REQ-017 Latency: done SHALL be high during exactly the cycle after the Nth edge that follows the accepting edge.
REQ-018 Output s SHALL equal (a+b+ci) mod 2^N, and co SHALL equal bit N of a+b+ci, for the captured values.
REQ-019 DONE SHALL return to IDLE on the next edge.
REQ-020 Outputs s and co SHALL hold their result through IDLE until the next accepting edge, where they clear to 0.
REQ-021 Output busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-022 Output done SHALL be 1 only in DONE.
REQ-023 An asserted start in RUN or DONE SHALL be ignored, with no queuing.
REQ-024 A start held high continuously SHALL cause back-to-back operations, each N+2 cycles long.
REQ-025 The counter SHALL be ceil(log2(N+1)) bits wide and SHALL not wrap within an operation.
REQ-026 With N=1, the block SHALL complete in one RUN edge with identical rules.

Reset
REQ-027 While rst=1 on an edge, the block SHALL go to IDLE and clear to 0: s, co, busy, done, the carry flop, the counter and the operand registers.
REQ-028 Reset mid-operation SHALL abort the operation with no done pulse.
REQ-029 rst SHALL take priority over start on the same edge.
REQ-030 A start on the first edge after rst deasserts SHALL be accepted normally.

Structure
REQ-031 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default width constant SHALL reside in a shared package, serial_adder_pkg.
REQ-032 The per-bit addition SHALL instantiate the team's existing fa_dataflow full adder as the only sub-module; there SHALL be no other arithmetic operator on the datapath.
REQ-033 Storage SHALL consist of the FSM register, three N-bit shift registers, the carry flop and the counter only.

Verification
REQ-034 With N=8, a=8'h3C, b=8'h0F, ci=0, pulse start -> done on the 8th edge after acceptance, s=8'h4B, co=0, busy high for 9 cycles.
REQ-035 With N=8, a=8'hFF, b=8'h01, ci=0 -> s=8'h00, co=1; then a=8'hA5, b=8'h5A, ci=1 -> s=8'h00, co=1.
REQ-036 With N=1, apply all eight {ci,a,b} combinations 000..111 -> {co,s} SHALL be 00,01,01,10,01,10,10,11.
REQ-037 With N=8, a=8'h12, b=8'h34, ci=0, then start=1 with a=8'hFF on the 3rd RUN edge -> s=8'h46, co=0, exactly one done pulse.
REQ-038 With N=8, assert rst after 3 RUN edges -> busy=0, s=0, co=0, no done; then a=8'h80, b=8'h80, ci=1 -> s=8'h01, co=1.
REQ-039 With start held high for 3 operations -> done pulses spaced exactly N+2=10 cycles apart, each with the correct sum.
